ot_tx_buffered: RTL

OT_TX_BUFFERED -- requirements
Module: ot_tx_buffered

---
 rtl/ot_tx_buffered.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ot_tx_buffered.sv
// Buffered serial transmitter: FIFO feeding an LSB-first start/data/stop framer.
// Define OT_TX_PARITY_EN to add an even parity bit between data and stop.
module ot_tx_buffered #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk_50m,
    input  logic                        rstn,
    input  logic                        clken,
    input  logic [DATA_BITS-1:0]        din,
    input  logic                        wr_en,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        ovf,
    input  logic                        ovf_clr,
    output logic                        Tx,
    output logic                        tx_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(DATA_BITS) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        STOP   = 2'd2
`ifdef OT_TX_PARITY_EN
        ,
        PARITY = 2'd3
`endif
    } state_t;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        count_d;
    logic                 ovf_q;

    state_t               state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [IW-1:0]        idx_q;
    logic                 stop_q;
    logic                 tx_q;

    logic                 wr_acc;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    assign full       = (count_q == DEPTH_C);
    assign fifo_count = count_q;
    assign ovf        = ovf_q;
    assign Tx         = tx_q;
    assign tx_busy    = (state_q != IDLE);

    assign head   = mem_q[rd_ptr_q];
    assign wr_acc = wr_en & ~full;
    // stop_q marks that the stop bit has already been on the line for a period
    assign pop    = clken && (count_q != '0) &&
                    ((state_q == IDLE) || (state_q == STOP && stop_q));

    always_comb begin
        count_d = count_q;
        unique case ({wr_acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk_50m or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            if (wr_en && full) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

`ifdef OT_TX_PARITY_EN
    logic par_q;

    always_ff @(posedge clk_50m or negedge rstn) begin
        if (!rstn) begin
            par_q <= 1'b0;
        end else if (pop) begin
            par_q <= ^head;
        end
    end
`endif

    always_ff @(posedge clk_50m or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else if (clken) begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        shift_q <= head;
                        idx_q   <= '0;
                        tx_q    <= 1'b0;
                        state_q <= DATA;
                    end else begin
                        tx_q    <= 1'b1;
                    end
                end
                DATA: begin
                    tx_q    <= shift_q[0];
                    shift_q <= shift_q >> 1;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        stop_q  <= 1'b0;
`ifdef OT_TX_PARITY_EN
                        state_q <= PARITY;
`else
                        state_q <= STOP;
`endif
                    end
                end
`ifdef OT_TX_PARITY_EN
                PARITY: begin
                    tx_q    <= par_q;
                    stop_q  <= 1'b0;
                    state_q <= STOP;
                end
`endif
                STOP: begin
                    if (!stop_q) begin
                        tx_q    <= 1'b1;
                        stop_q  <= 1'b1;
                    end else if (pop) begin
                        shift_q <= head;
                        idx_q   <= '0;
                        tx_q    <= 1'b0;
                        stop_q  <= 1'b0;
                        state_q <= DATA;
                    end else begin
                        tx_q    <= 1'b1;
                        stop_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
